dds_dual_ch_sched: RTL

- Two-channel DDS controller. Time-multiplexes one shared single-port synchronous ROM (1-cycle read latency, registered q) between two independent phase-accumulator channels.
- Each channel has its own frequency word, phase offset and enable. Each channel gets a ROM slot every other cycle, so its maximum sample rate is clk/2.
- Sits between the register/config logic and the waveform ROM. Delivers per-channel sample + valid strobes to downstream DAC/mixing logic.

---
 rtl/dds_dual_ch_sched.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dds_dual_ch_sched.sv
// Two-channel DDS controller sharing one synchronous waveform ROM.
// Even slots serve channel 0, odd slots serve channel 1.
module dds_dual_ch_sched #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ch0_en,
    input  logic                   ch1_en,
    input  logic                   cfg_wr,
    input  logic                   cfg_ch,
    input  logic [PHASE_WIDTH-1:0] cfg_fword,
    input  logic [PHASE_WIDTH-1:0] cfg_pword,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [DATA_WIDTH-1:0]  rom_q,
    output logic [DATA_WIDTH-1:0]  ch0_data,
    output logic                   ch0_valid,
    output logic [DATA_WIDTH-1:0]  ch1_data,
    output logic                   ch1_valid
);

    logic                   r_slot;
    logic [PHASE_WIDTH-1:0] r_acc0;
    logic [PHASE_WIDTH-1:0] r_acc1;
    logic [PHASE_WIDTH-1:0] r_fw0;
    logic [PHASE_WIDTH-1:0] r_fw1;
    logic [PHASE_WIDTH-1:0] r_pw0;
    logic [PHASE_WIDTH-1:0] r_pw1;
    logic [ADDR_WIDTH-1:0]  r_rom_addr;
    logic                   r_tag0_v;
    logic                   r_tag0_ch;
    logic                   r_tag1_v;
    logic                   r_tag1_ch;
    logic [DATA_WIDTH-1:0]  r_ch0_data;
    logic [DATA_WIDTH-1:0]  r_ch1_data;
    logic                   r_ch0_valid;
    logic                   r_ch1_valid;

    logic                   w_en;
    logic [PHASE_WIDTH-1:0] w_acc;
    logic [PHASE_WIDTH-1:0] w_fw;
    logic [PHASE_WIDTH-1:0] w_pw;
    logic [PHASE_WIDTH-1:0] w_phase;
    logic [PHASE_WIDTH-1:0] w_acc_nxt;
    logic [ADDR_WIDTH-1:0]  w_addr;

    assign w_en      = r_slot ? ch1_en : ch0_en;
    assign w_acc     = r_slot ? r_acc1 : r_acc0;
    assign w_fw      = r_slot ? r_fw1  : r_fw0;
    assign w_pw      = r_slot ? r_pw1  : r_pw0;
    assign w_phase   = w_acc + w_pw;
    assign w_acc_nxt = w_acc + w_fw;
    assign w_addr    = ADDR_WIDTH'(w_phase >> (PHASE_WIDTH - ADDR_WIDTH));

    assign rom_addr  = r_rom_addr;
    assign ch0_data  = r_ch0_data;
    assign ch1_data  = r_ch1_data;
    assign ch0_valid = r_ch0_valid;
    assign ch1_valid = r_ch1_valid;

    // Slot toggles every cycle, independent of the enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_slot <= 1'b0;
        else     r_slot <= ~r_slot;
    end

    // Advance the owning channel's accumulator; a disabled channel rests at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc0 <= '0;
            r_acc1 <= '0;
        end else if (!r_slot) begin
            r_acc0 <= ch0_en ? w_acc_nxt : '0;
        end else begin
            r_acc1 <= ch1_en ? w_acc_nxt : '0;
        end
    end

    // Config words; an issue on the same edge still sees the old words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fw0 <= '0;
            r_fw1 <= '0;
            r_pw0 <= '0;
            r_pw1 <= '0;
        end else if (cfg_wr) begin
            if (cfg_ch) begin
                r_fw1 <= cfg_fword;
                r_pw1 <= cfg_pword;
            end else begin
                r_fw0 <= cfg_fword;
                r_pw0 <= cfg_pword;
            end
        end
    end

    // Issue stage: drive the ROM address and tag the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rom_addr <= '0;
            r_tag0_v   <= 1'b0;
            r_tag0_ch  <= 1'b0;
        end else begin
            if (w_en) r_rom_addr <= w_addr;
            r_tag0_v  <= w_en;
            r_tag0_ch <= r_slot;
        end
    end

    // Tag follows the ROM's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag1_v  <= 1'b0;
            r_tag1_ch <= 1'b0;
        end else begin
            r_tag1_v  <= r_tag0_v;
            r_tag1_ch <= r_tag0_ch;
        end
    end

    // Capture ROM data into the tagged channel and strobe its valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch0_data  <= '0;
            r_ch1_data  <= '0;
            r_ch0_valid <= 1'b0;
            r_ch1_valid <= 1'b0;
        end else begin
            r_ch0_valid <= r_tag1_v & ~r_tag1_ch;
            r_ch1_valid <= r_tag1_v &  r_tag1_ch;
            if (r_tag1_v && !r_tag1_ch) r_ch0_data <= rom_q;
            if (r_tag1_v &&  r_tag1_ch) r_ch1_data <= rom_q;
        end
    end

endmodule
